// File: rtl/rat_intr_pkg.sv
// Shared types and default constants for the RAT MCU interrupt controller.
package rat_intr_pkg;

  // Largest number of sources the 3-bit ID field can name.
  localparam int MAX_SRC = 8;

  // Default IN/OUT port addresses used by the ISR.
  localparam logic [7:0] DEF_MASK_PORT = 8'hE0;
  localparam logic [7:0] DEF_ACK_PORT  = 8'hE1;
  localparam logic [7:0] DEF_STAT_PORT = 8'hE2;

  // Default quiet time on INTR_OUT after acknowledge or withdraw.
  localparam int DEF_GAP_CYCLES = 2;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

endpackage

// File: rtl/rat_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins.
module rat_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Multi-source interrupt controller for the RAT MCU: edge-detects up to
// eight request lines, keeps them pending until software acknowledges,
// masks and priority-resolves them onto the single INTR_OUT line, and
// exposes mask / in-service ID / pending through the MCU port space.
//
// OUT handshake: a write is taken on any CLK edge where IO_STRB=1, with
// PORT_ID selecting the register and OUT_PORT carrying data; there is no
// back-pressure. Reads are purely combinational on PORT_ID and have no
// side effects.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         N_SRC      = 8,
  parameter logic [7:0] MASK_PORT  = DEF_MASK_PORT,
  parameter logic [7:0] ACK_PORT   = DEF_ACK_PORT,
  parameter logic [7:0] STAT_PORT  = DEF_STAT_PORT,
  parameter int         GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_SRC,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic             INTR_OUT,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT,
  output state_e           STATE_DBG
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [2:0]       id_q, id_d;
  state_e           state_q, state_d;
  logic [3:0]       gap_q, gap_d;
  logic             intr_q, intr_d;

  logic [N_SRC-1:0] irq_rise;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] active;
  logic             wr_mask;
  logic             wr_ack;
  logic             ack_ok;
  logic             ack_hits_id;
  logic             withdraw;
  logic [2:0]       enc_idx;
  logic             enc_valid;
  logic [7:0]       mask_ext;
  logic [7:0]       pend_ext;

  // Write decode, edge detect and pending/mask next values.
  always_comb begin
    wr_mask     = IO_STRB && (PORT_ID == MASK_PORT);
    wr_ack      = IO_STRB && (PORT_ID == ACK_PORT);
    // Out-of-range IDs and junk in the upper bits are silently dropped.
    ack_ok      = wr_ack && (OUT_PORT[7:3] == 5'd0) &&
                  (int'(OUT_PORT[2:0]) < N_SRC);
    ack_clr     = '0;
    if (ack_ok) begin
      ack_clr[OUT_PORT[2:0]] = 1'b1;
    end
    irq_rise    = IRQ_SRC & ~prev_q;
    prev_d      = IRQ_SRC;
    // A new edge beats a same-cycle acknowledge of that bit.
    pend_d      = (pend_q & ~ack_clr) | irq_rise;
    mask_d      = wr_mask ? OUT_PORT[N_SRC-1:0] : mask_q;
    active      = pend_q & mask_q;
    ack_hits_id = ack_ok && (OUT_PORT[2:0] == id_q);
    withdraw    = wr_mask && !OUT_PORT[id_q];
  end

  rat_prio_enc #(
    .N (N_SRC)
  ) u_prio (
    .req   (active),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // State register plus all controller flops; reset is synchronous.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Loading prev from the live lines hides levels already high at release.
      prev_q  <= IRQ_SRC;
      pend_q  <= '0;
      mask_q  <= '0;
      id_q    <= '0;
      state_q <= ST_IDLE;
      gap_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      intr_q  <= intr_d;
    end
  end

  // Next-state logic: latch the winner in IDLE, hold it through ASSERT
  // (no preemption), then sit out the quiet gap.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          id_d    = enc_idx;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (ack_hits_id || withdraw) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: INTR_OUT is a flop that mirrors the ASSERT state.
  always_comb begin
    intr_d = (state_d == ST_ASSERT);
  end

  // Combinational read mux for the IN_PORT path.
  always_comb begin
    mask_ext              = '0;
    mask_ext[N_SRC-1:0]   = mask_q;
    pend_ext              = '0;
    pend_ext[N_SRC-1:0]   = pend_q;
    RD_HIT                = 1'b0;
    RD_DATA               = 8'h00;
    if (PORT_ID == MASK_PORT) begin
      RD_HIT  = 1'b1;
      RD_DATA = mask_ext;
    end else if (PORT_ID == ACK_PORT) begin
      RD_HIT  = 1'b1;
      RD_DATA = {(state_q == ST_ASSERT), 4'b0000, id_q};
    end else if (PORT_ID == STAT_PORT) begin
      RD_HIT  = 1'b1;
      RD_DATA = pend_ext;
    end
  end

  assign INTR_OUT  = intr_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl: directed scenarios followed by a
// random phase, all checked against a cycle-level behavioural model.
module tb_rat_intr_ctrl;
  import rat_intr_pkg::*;

  localparam int GAP = 2;

  logic       CLK;
  logic       RESET;
  logic [7:0] IRQ_SRC;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       INTR_OUT;
  logic [7:0] RD_DATA;
  logic       RD_HIT;
  state_e     STATE_DBG;

  int total;
  int bad;

  // Behavioural model: pending/mask sets, whether a request is being
  // presented, which ID, and how many quiet cycles remain.
  bit [7:0] m_prev;
  bit [7:0] m_pend;
  bit [7:0] m_mask;
  int       m_id;
  bit       m_busy;
  int       m_gap;

  rat_intr_ctrl #(
    .N_SRC      (8),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IRQ_SRC   (IRQ_SRC),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .INTR_OUT  (INTR_OUT),
    .RD_DATA   (RD_DATA),
    .RD_HIT    (RD_HIT),
    .STATE_DBG (STATE_DBG)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int lowest_set(bit [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    bit [7:0] rise;
    bit [7:0] act;
    bit       wr_m;
    bit       ack_ok;
    if (RESET) begin
      m_pend = 0;
      m_mask = 0;
      m_id   = 0;
      m_busy = 0;
      m_gap  = 0;
      m_prev = IRQ_SRC;
      return;
    end
    rise   = IRQ_SRC & ~m_prev;
    m_prev = IRQ_SRC;
    wr_m   = IO_STRB && (PORT_ID == 8'hE0);
    ack_ok = IO_STRB && (PORT_ID == 8'hE1) && (OUT_PORT < 8);
    act    = m_pend & m_mask;
    if (m_busy) begin
      if ((ack_ok && int'(OUT_PORT) == m_id) || (wr_m && !OUT_PORT[m_id])) begin
        m_busy = 0;
        m_gap  = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (act != 0) begin
      m_id   = lowest_set(act);
      m_busy = 1;
    end
    if (ack_ok) m_pend[OUT_PORT[2:0]] = 1'b0;
    m_pend = m_pend | rise;
    if (wr_m) m_mask = OUT_PORT;
  endfunction

  function automatic bit [7:0] model_rd(bit [7:0] port);
    case (port)
      8'hE0:   return m_mask;
      8'hE1:   return {m_busy, 4'b0000, 3'(m_id)};
      8'hE2:   return m_pend;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare INTR_OUT against the model.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check("intr", {7'd0, INTR_OUT}, {7'd0, m_busy});
  endtask

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    PORT_ID  = port;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
  endtask

  task automatic rd_check(input logic [7:0] port);
    bit hit;
    PORT_ID = port;
    #1;
    hit = (port == 8'hE0) || (port == 8'hE1) || (port == 8'hE2);
    check("rd_data", RD_DATA, model_rd(port));
    check("rd_hit", {7'd0, RD_HIT}, {7'd0, hit});
    PORT_ID = 8'h00;
  endtask

  task automatic rd_const(input string tag, input logic [7:0] port, input logic [7:0] exp);
    PORT_ID = port;
    #1;
    check(tag, RD_DATA, exp);
    PORT_ID = 8'h00;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    m_prev   = 0;
    m_pend   = 0;
    m_mask   = 0;
    m_id     = 0;
    m_busy   = 0;
    m_gap    = 0;
    RESET    = 1'b1;
    IRQ_SRC  = 8'h01;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;

    // Reset with line 0 already high: no edge at release.
    tick();
    tick();
    RESET = 1'b0;
    wr(8'hE0, 8'hFF);
    tick();
    tick();
    rd_const("reset_stat", 8'hE2, 8'h00);
    rd_const("reset_mask", 8'hE0, 8'hFF);
    check("reset_intr", {7'd0, INTR_OUT}, 8'h00);

    // Single source 3: two-cycle latency, then acknowledge and gap.
    IRQ_SRC = 8'h09;
    tick();
    check("lat_early", {7'd0, INTR_OUT}, 8'h00);
    IRQ_SRC = 8'h01;
    tick();
    check("lat_intr", {7'd0, INTR_OUT}, 8'h01);
    rd_const("ack_rd3", 8'hE1, 8'h83);
    rd_const("stat3", 8'hE2, 8'h08);
    wr(8'hE1, 8'h03);
    check("gap_lo1", {7'd0, INTR_OUT}, 8'h00);
    tick();
    check("gap_lo2", {7'd0, INTR_OUT}, 8'h00);
    tick();
    tick();
    rd_const("stat_clr", 8'hE2, 8'h00);

    // Simultaneous 5 and 2: lowest index first, then 5 after the gap.
    IRQ_SRC = 8'h25;
    tick();
    IRQ_SRC = 8'h01;
    tick();
    rd_const("prio_id2", 8'hE1, 8'h82);
    wr(8'hE1, 8'h02);
    tick();
    tick();
    tick();
    rd_const("prio_id5", 8'hE1, 8'h85);
    wr(8'hE1, 8'h05);
    tick();
    tick();
    tick();

    // Fully masked: pending still latches, no request until unmasked.
    wr(8'hE0, 8'h00);
    IRQ_SRC = 8'h03;
    tick();
    IRQ_SRC = 8'h01;
    tick();
    rd_const("masked_stat", 8'hE2, 8'h02);
    check("masked_intr", {7'd0, INTR_OUT}, 8'h00);
    wr(8'hE0, 8'h02);
    check("unmask_wait", {7'd0, INTR_OUT}, 8'h00);
    tick();
    check("unmask_intr", {7'd0, INTR_OUT}, 8'h01);
    wr(8'hE1, 8'h01);
    tick();
    tick();
    tick();

    // Withdraw by masking the in-service source.
    wr(8'hE0, 8'hFF);
    IRQ_SRC = 8'h11;
    tick();
    IRQ_SRC = 8'h01;
    tick();
    rd_const("wd_id4", 8'hE1, 8'h84);
    wr(8'hE0, 8'hEF);
    check("wd_intr", {7'd0, INTR_OUT}, 8'h00);
    tick();
    tick();
    tick();
    rd_const("wd_stat", 8'hE2, 8'h10);
    rd_const("wd_ack", 8'hE1, 8'h04);
    check("wd_idle", {7'd0, INTR_OUT}, 8'h00);

    // Edge on 6 coincides with its acknowledge: set wins, request returns.
    wr(8'hE1, 8'h04);
    wr(8'hE0, 8'h40);
    IRQ_SRC = 8'h41;
    tick();
    IRQ_SRC = 8'h01;
    tick();
    tick();
    IRQ_SRC = 8'h41;
    wr(8'hE1, 8'h06);
    IRQ_SRC = 8'h01;
    rd_const("race_stat", 8'hE2, 8'h40);
    tick();
    tick();
    tick();
    check("race_reassert", {7'd0, INTR_OUT}, 8'h01);
    rd_const("race_id6", 8'hE1, 8'h86);
    wr(8'hE1, 8'h09);
    rd_const("bad_ack_stat", 8'hE2, 8'h40);
    check("bad_ack_intr", {7'd0, INTR_OUT}, 8'h01);
    rd_const("miss_port", 8'h10, 8'h00);
    wr(8'hE1, 8'h06);
    tick();
    tick();
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int op;
      IRQ_SRC = 8'($urandom & $urandom);
      RESET   = ($urandom_range(0, 99) == 0);
      op      = $urandom_range(0, 9);
      if (op <= 1) begin
        PORT_ID  = 8'hE0;
        OUT_PORT = 8'($urandom);
        IO_STRB  = 1'b1;
      end else if (op <= 4) begin
        PORT_ID  = 8'hE1;
        OUT_PORT = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
        IO_STRB  = 1'b1;
      end else if (op == 5) begin
        PORT_ID  = 8'hE2;
        OUT_PORT = 8'($urandom);
        IO_STRB  = 1'b1;
      end else begin
        IO_STRB  = 1'b0;
      end
      tick();
      IO_STRB = 1'b0;
      RESET   = 1'b0;
      rd_check(8'hE0);
      rd_check(8'hE1);
      rd_check(8'hE2);
      rd_check(8'($urandom_range(0, 223)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
